// File: rtl/lsu_ctrl.sv
// Load/store controller between the MEM stage and the data-memory port.
// One access at a time: alignment check, doubleword-aligned masked request,
// then sign/zero-extended load data or a store completion to the pipeline.
//
// state | meaning
// IDLE  | ready for a new request
// REQ   | mem_ce high, request held until mem_gnt
// WAIT  | request granted, waiting for mem_rvalid
// RESP  | result (or misalign fault) presented until out_ready
module lsu_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_we,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   input  logic [63:0] in_addr,
   input  logic [63:0] in_wdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_rdata,
   output logic        out_misalign,
   output logic        mem_ce,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t      state, state_nxt;
   logic        we_q, uns_q, misalign_q;
   logic [1:0]  size_q;
   logic [2:0]  off_q;
   logic [63:0] addr_q, wdata_q, rdata_q;
   logic [7:0]  wmask_q;

   logic        misalign;
   logic [7:0]  mask_base;
   logic [63:0] shifted, ext;

   // Alignment check and byte-lane mask for the incoming request
   always_comb begin
      misalign  = 1'b0;
      mask_base = 8'h01;
      case (in_size)
         2'd0: begin misalign = 1'b0;             mask_base = 8'h01; end
         2'd1: begin misalign = in_addr[0];       mask_base = 8'h03; end
         2'd2: begin misalign = |in_addr[1:0];    mask_base = 8'h0F; end
         default: begin misalign = |in_addr[2:0]; mask_base = 8'hFF; end
      endcase
   end

   // Load data: move the addressed lane down, then extend to 64 bits
   always_comb begin
      shifted = mem_rdata >> {off_q, 3'b000};
      ext     = shifted;
      case (size_q)
         2'd0: ext = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
         2'd1: ext = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
         2'd2: ext = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
         default: ext = shifted;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = misalign ? RESP : REQ;
         REQ:  if (mem_gnt) state_nxt = WAIT;
         WAIT: if (mem_rvalid) state_nxt = RESP;
         RESP: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from the state register and latched request fields
   always_comb begin
      in_ready     = (state == IDLE);
      mem_ce       = (state == REQ);
      mem_we       = (state == REQ) && we_q;
      out_valid    = (state == RESP);
      out_misalign = (state == RESP) && misalign_q;
      out_rdata    = rdata_q;
      mem_addr     = addr_q;
      mem_wdata    = wdata_q;
      mem_wmask    = wmask_q;
   end

   // Request capture on accept, load data capture on the memory response
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q       <= 1'b0;
         uns_q      <= 1'b0;
         misalign_q <= 1'b0;
         size_q     <= 2'd0;
         off_q      <= 3'd0;
         addr_q     <= 64'd0;
         wdata_q    <= 64'd0;
         wmask_q    <= 8'd0;
         rdata_q    <= 64'd0;
      end else if (state == IDLE && in_valid) begin
         we_q       <= in_we;
         uns_q      <= in_unsigned;
         misalign_q <= misalign;
         size_q     <= in_size;
         off_q      <= in_addr[2:0];
         addr_q     <= {in_addr[63:3], 3'b000};
         wdata_q    <= in_wdata << {in_addr[2:0], 3'b000};
         wmask_q    <= in_we ? (mask_base << in_addr[2:0]) : 8'd0;
         rdata_q    <= 64'd0;
      end else if (state == WAIT && mem_rvalid && !we_q) begin
         rdata_q    <= ext;
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small reactive memory/pipeline driver.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_we, in_unsigned;
   logic [1:0]  in_size;
   logic [63:0] in_addr, in_wdata, out_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        out_valid, out_ready, out_misalign, mem_ce, mem_we, mem_gnt, mem_rvalid;
   logic [7:0]  mem_wmask;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lsu_ctrl dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_size(in_size),
      .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
      .out_misalign(out_misalign),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   // Runs one transaction; gd/rd/od are extra cycles before gnt/rvalid/out_ready.
   // lat is the cycle (1 = cycle after the accept edge) where out_valid first rises.
   task automatic xfer(input logic we, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rdat, input int gd, input int rd, input int od,
                       output logic ce_seen, output logic req_unstable, output logic ir_bad,
                       output logic [63:0] maddr, output logic mwe,
                       output logic [63:0] mwdata, output logic [7:0] mwmask,
                       output int lat, output logic [63:0] ordata, output logic omis,
                       output logic rd_unstable, output logic tmo);
      int ce_n = 0, w_n = 0, r_n = 0;
      logic waiting = 1'b0, done = 1'b0;
      ce_seen = 0; req_unstable = 0; ir_bad = 0; rd_unstable = 0;
      maddr = '0; mwe = 0; mwdata = '0; mwmask = '0; lat = 0; ordata = '0; omis = 0;
      in_valid = 1; in_we = we; in_size = size; in_unsigned = uns;
      in_addr = addr; in_wdata = wdata;
      @(posedge clk); #1;
      in_valid = 0; in_wdata = 64'hA5A5_A5A5_A5A5_A5A5; in_addr = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int k = 1; k <= 40 && !done; k++) begin
         @(negedge clk);
         if (in_ready) ir_bad = 1;
         if (mem_ce) begin
            if (ce_n == 0) begin
               ce_seen = 1; maddr = mem_addr; mwe = mem_we; mwdata = mem_wdata; mwmask = mem_wmask;
            end else if (maddr !== mem_addr || mwe !== mem_we || mwdata !== mem_wdata ||
                         mwmask !== mem_wmask) req_unstable = 1;
            ce_n++;
         end
         if (waiting) begin
            w_n++;
            mem_rdata  = rdat;
            mem_rvalid = (w_n > rd);
            if (mem_rvalid) waiting = 0;
         end else mem_rvalid = 0;
         mem_gnt = mem_ce && (ce_n > gd);
         if (mem_gnt) waiting = 1;
         if (out_valid) begin
            if (lat == 0) begin lat = k; ordata = out_rdata; omis = out_misalign; end
            else if (ordata !== out_rdata || omis !== out_misalign) rd_unstable = 1;
            r_n++;
            out_ready = (r_n > od);
            if (out_ready) done = 1;
         end else out_ready = 0;
      end
      tmo = !done;
      @(posedge clk); #1;
      out_ready = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 64'hDEAD_0BAD_DEAD_0BAD;
   endtask

   logic        ce_s, req_u, ir_b, mwe_o, omis_o, rd_u, tmo_o;
   logic [63:0] maddr_o, mwd_o, ord_o;
   logic [7:0]  mwm_o;
   int          lat_o;

   task automatic test_reset();
      rst = 1; @(posedge clk); @(posedge clk); #1; rst = 0;
      total++;
      if ({in_ready, out_valid, out_misalign, mem_ce, mem_we} !== 5'b10000) begin
         bad++; $display("FAIL reset_ctrl got=%b want=10000",
                         {in_ready, out_valid, out_misalign, mem_ce, mem_we});
      end
      total++;
      if ({out_rdata, mem_addr, mem_wdata, mem_wmask} !== '0) begin
         bad++; $display("FAIL reset_data rdata=%h addr=%h wdata=%h wmask=%h want all 0",
                         out_rdata, mem_addr, mem_wdata, mem_wmask);
      end
   endtask

   task automatic test_load_byte();
      logic [63:0] addrs [4] = '{64'h8000_0003, 64'h8000_0005, 64'h8000_0004, 64'h8000_0003};
      logic [63:0] exps  [4] = '{64'hFFFF_FFFF_FFFF_FF85, 64'h33, 64'h44, 64'h85};
      logic        unss  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         xfer(0, 2'd0, unss[i], addrs[i], '0, 64'h1122_3344_8566_7788, 0, 0, 0,
              ce_s, req_u, ir_b, maddr_o, mwe_o, mwd_o, mwm_o, lat_o, ord_o, omis_o, rd_u, tmo_o);
         total++;
         if (ord_o !== exps[i] || tmo_o) begin
            bad++; $display("FAIL lb_rdata[%0d] got=%h want=%h tmo=%b", i, ord_o, exps[i], tmo_o);
         end
         total++;
         if (maddr_o !== 64'h8000_0000 || mwm_o !== 8'h00 || mwe_o !== 1'b0) begin
            bad++; $display("FAIL lb_req[%0d] addr=%h wmask=%h we=%b want 80000000/00/0",
                            i, maddr_o, mwm_o, mwe_o);
         end
         total++;
         if (lat_o !== 3 || omis_o !== 1'b0) begin
            bad++; $display("FAIL lb_lat[%0d] got=%0d mis=%b want 3/0", i, lat_o, omis_o);
         end
      end
   endtask

   task automatic test_load_word_half();
      xfer(0, 2'd2, 1, 64'h8000_0004, '0, 64'h8765_4321_0000_0000, 0, 0, 0,
           ce_s, req_u, ir_b, maddr_o, mwe_o, mwd_o, mwm_o, lat_o, ord_o, omis_o, rd_u, tmo_o);
      total++;
      if (ord_o !== 64'h0000_0000_8765_4321) begin
         bad++; $display("FAIL lw_unsigned got=%h want=0000000087654321", ord_o);
      end
      xfer(0, 2'd2, 0, 64'h8000_0004, '0, 64'h8765_4321_0000_0000, 0, 0, 0,
           ce_s, req_u, ir_b, maddr_o, mwe_o, mwd_o, mwm_o, lat_o, ord_o, omis_o, rd_u, tmo_o);
      total++;
      if (ord_o !== 64'hFFFF_FFFF_8765_4321) begin
         bad++; $display("FAIL lw_signed got=%h want=ffffffff87654321", ord_o);
      end
      xfer(0, 2'd1, 0, 64'h8000_0012, '0, 64'h0000_0000_F00D_0000, 0, 0, 0,
           ce_s, req_u, ir_b, maddr_o, mwe_o, mwd_o, mwm_o, lat_o, ord_o, omis_o, rd_u, tmo_o);
      total++;
      if (ord_o !== 64'hFFFF_FFFF_FFFF_F00D || maddr_o !== 64'h8000_0010) begin
         bad++; $display("FAIL lh_signed got=%h addr=%h want=fffffffffffff00d/80000010",
                         ord_o, maddr_o);
      end
   endtask

   task automatic test_store();
      xfer(1, 2'd1, 0, 64'h8000_0006, 64'hDEAD_BEEF, 64'h1234_5678_9ABC_DEF0, 0, 0, 0,
           ce_s, req_u, ir_b, maddr_o, mwe_o, mwd_o, mwm_o, lat_o, ord_o, omis_o, rd_u, tmo_o);
      total++;
      if (mwe_o !== 1'b1 || mwd_o !== 64'hBEEF_0000_0000_0000 || mwm_o !== 8'hC0 ||
          maddr_o !== 64'h8000_0000) begin
         bad++; $display("FAIL sh_req we=%b wdata=%h wmask=%h addr=%h want 1/beef000000000000/c0/80000000",
                         mwe_o, mwd_o, mwm_o, maddr_o);
      end
      total++;
      if (ord_o !== 64'd0 || lat_o !== 3 || tmo_o) begin
         bad++; $display("FAIL sh_resp rdata=%h lat=%0d want 0/3", ord_o, lat_o);
      end
      xfer(1, 2'd0, 0, 64'h8000_0001, 64'h0000_0000_0000_01AB, 64'd0, 0, 0, 0,
           ce_s, req_u, ir_b, maddr_o, mwe_o, mwd_o, mwm_o, lat_o, ord_o, omis_o, rd_u, tmo_o);
      total++;
      if (mwd_o !== 64'h0000_0000_0001_AB00 || mwm_o !== 8'h02) begin
         bad++; $display("FAIL sb_req wdata=%h wmask=%h want 000000000001ab00/02", mwd_o, mwm_o);
      end
   endtask

   task automatic test_misalign();
      xfer(0, 2'd2, 0, 64'h8000_0002, '0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0,
           ce_s, req_u, ir_b, maddr_o, mwe_o, mwd_o, mwm_o, lat_o, ord_o, omis_o, rd_u, tmo_o);
      total++;
      if (ce_s !== 1'b0) begin
         bad++; $display("FAIL mis_ce got=%b want=0", ce_s);
      end
      total++;
      if (lat_o !== 1 || omis_o !== 1'b1 || ord_o !== 64'd0) begin
         bad++; $display("FAIL mis_resp lat=%0d mis=%b rdata=%h want 1/1/0", lat_o, omis_o, ord_o);
      end
      xfer(1, 2'd3, 0, 64'h8000_0004, 64'h1, '0, 0, 0, 0,
           ce_s, req_u, ir_b, maddr_o, mwe_o, mwd_o, mwm_o, lat_o, ord_o, omis_o, rd_u, tmo_o);
      total++;
      if (ce_s !== 1'b0 || omis_o !== 1'b1 || lat_o !== 1) begin
         bad++; $display("FAIL mis_sd ce=%b mis=%b lat=%0d want 0/1/1", ce_s, omis_o, lat_o);
      end
   endtask

   task automatic test_stalls();
      xfer(0, 2'd3, 1, 64'h8000_0008, 64'h5555, 64'h8123_4567_89AB_CDEF, 3, 2, 2,
           ce_s, req_u, ir_b, maddr_o, mwe_o, mwd_o, mwm_o, lat_o, ord_o, omis_o, rd_u, tmo_o);
      total++;
      if (lat_o !== 8 || tmo_o) begin
         bad++; $display("FAIL stall_lat got=%0d want=8 tmo=%b", lat_o, tmo_o);
      end
      total++;
      if (ord_o !== 64'h8123_4567_89AB_CDEF || rd_u) begin
         bad++; $display("FAIL stall_rdata got=%h unstable=%b want 8123456789abcdef/0", ord_o, rd_u);
      end
      total++;
      if (req_u || maddr_o !== 64'h8000_0008 || ir_b) begin
         bad++; $display("FAIL stall_req unstable=%b addr=%h in_ready_seen=%b want 0/80000008/0",
                         req_u, maddr_o, ir_b);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL stall_turnaround in_ready=%b want=1", in_ready);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic ov_seen = 1'b0;
      in_valid = 1; in_we = 0; in_size = 2'd3; in_unsigned = 0; in_addr = 64'h8000_0010;
      @(posedge clk); #1; in_valid = 0;
      mem_gnt = 1;
      @(posedge clk); #1; mem_gnt = 0;
      total++;
      if (mem_ce !== 1'b0 || in_ready !== 1'b0 || mem_addr !== 64'h8000_0010) begin
         bad++; $display("FAIL rw_wait ce=%b in_ready=%b addr=%h want 0/0/80000010",
                         mem_ce, in_ready, mem_addr);
      end
      rst = 1;
      @(posedge clk); #1; rst = 0;
      total++;
      if ({in_ready, out_valid, out_misalign, mem_ce, mem_we} !== 5'b10000 ||
          {out_rdata, mem_addr, mem_wdata, mem_wmask} !== '0) begin
         bad++; $display("FAIL rw_reset ctrl=%b addr=%h rdata=%h want 10000/0/0",
                         {in_ready, out_valid, out_misalign, mem_ce, mem_we}, mem_addr, out_rdata);
      end
      mem_rdata = 64'h7777_7777_7777_7777; mem_rvalid = 1;
      @(posedge clk); #1; mem_rvalid = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (out_valid || mem_ce || !in_ready || out_rdata !== 64'd0) ov_seen = 1;
      end
      total++;
      if (ov_seen) begin
         bad++; $display("FAIL rw_abandon activity_seen=%b want=0", ov_seen);
      end
   endtask

   initial begin
      rst = 1; in_valid = 0; in_we = 0; in_size = 0; in_unsigned = 0;
      in_addr = '0; in_wdata = '0; out_ready = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
      #1;
      test_reset();
      test_load_byte();
      test_load_word_half();
      test_store();
      test_misalign();
      test_stalls();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
